// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart transmit scheduler and future rx/CSR arbiters.
package uart_pkg;

  localparam int FRAME_WD_DEF = 8;
  localparam int RR_MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } sched_state_t;

  // One-hot grant to the first set bit after 'last', wrapping modulo n (n <= RR_MAX_REQ).
  function automatic logic [RR_MAX_REQ-1:0] rr_next_grant(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [2:0]            last,
    input int                    n
  );
    logic [RR_MAX_REQ-1:0] gnt;
    logic [2:0]            idx;
    gnt = '0;
    for (int k = 1; k <= RR_MAX_REQ; k++) begin
      if (k <= n) begin
        idx = 3'((int'(last) + k) % n);
        if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [RR_MAX_REQ-1:0] req_w;
  logic [RR_MAX_REQ-1:0] gnt_w;

  always_comb begin
    req_w          = '0;
    req_w[N-1:0]   = req;
    gnt_w          = rr_next_grant(req_w, 3'(last_gnt), N);
    gnt            = gnt_w[N-1:0];
    gnt_any        = |gnt_w;
    gnt_idx        = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_w[i]) gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one tx serializer among NUM_REQ producers with round-robin arbitration,
// a programmable inter-frame gap and a watchdog on tx_done.
//   state     | meaning
//   IDLE      | arbitrate, accept one frame
//   LAUNCH    | pulse frame_en, clear watchdog
//   WAIT_DONE | hold data_frame, wait for tx_done or watchdog expiry
//   GAP       | enforce inter-frame idle time
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  FRAME_WD    = FRAME_WD_DEF,
  parameter int  GAP_CYC     = 16,
  parameter int  TIMEOUT_CYC = 131072,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*FRAME_WD-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        frame_en,
  output logic [FRAME_WD-1:0]         data_frame,
  input  logic                        tx_done,
  output logic                        busy,
  output logic                        done_pulse,
  output logic                        timeout_err,
  output logic [ID_W-1:0]             done_id
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sched_state_t          state, state_nx;
  logic [ID_W-1:0]       last_gnt;
  logic [ID_W-1:0]       cur_id;
  logic [TO_W-1:0]       to_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [FRAME_WD-1:0]   sel_data;
  logic                  gap_end;
  logic                  to_hit;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) sel_data = req_data[i*FRAME_WD +: FRAME_WD];
    end
  end

  // GAP_CYC == 0 still spends one cycle in GAP
  assign gap_end = (GAP_CYC == 0) || (gap_cnt == GAP_LAST);
  assign to_hit  = (to_cnt == TO_LAST);

  always_comb begin
    state_nx  = state;
    frame_en  = 1'b0;
    busy      = 1'b1;
    req_ready = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!rst) req_ready = gnt;
        if (gnt_any) state_nx = LAUNCH;
      end
      LAUNCH: begin
        frame_en = 1'b1;
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done || to_hit) state_nx = GAP;
      end
      GAP: begin
        if (gap_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= ID_W'(NUM_REQ - 1);
      cur_id      <= '0;
      data_frame  <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      done_id     <= '0;
    end else begin
      state       <= state_nx;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            data_frame <= sel_data;
            cur_id     <= gnt_idx;
            last_gnt   <= gnt_idx;
          end
        end
        LAUNCH: to_cnt <= '0;
        WAIT_DONE: begin
          to_cnt  <= to_cnt + 1'b1;
          gap_cnt <= '0;
          // tx_done has priority over a coincident watchdog expiry
          if (tx_done) begin
            done_pulse <= 1'b1;
            done_id    <= cur_id;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            done_id     <= cur_id;
          end
        end
        GAP: begin
          if (!gap_end) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one tx serializer among NUM_REQ byte producers.
- Accepts one frame per valid/ready handshake and drives tx's frame_en/data_frame.
- Holds data_frame stable until tx_done, then enforces a programmable inter-frame gap.
- A watchdog aborts a frame whose tx_done never arrives and reports which requester it belonged to.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FRAME_WD, 8, data bits per frame; must equal the tx instance's FRAME_WD.
- GAP_CYC, 16, idle clk cycles after each frame before the next arbitration; 0 = no gap.
- TIMEOUT_CYC, 131072, max clk cycles in WAIT_DONE before abort; must exceed one full tx frame time.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester frame available
- req_data  in  NUM_REQ*FRAME_WD  flattened payloads; requester i in bits [i*FRAME_WD +: FRAME_WD]
- req_ready  out  NUM_REQ  one-hot accept; transfer occurs when req_valid[i]&req_ready[i]
- frame_en  out  1  one-cycle start pulse to tx
- data_frame  out  FRAME_WD  payload to tx, held from frame_en until leaving WAIT_DONE
- tx_done  in  1  one-cycle completion pulse from tx
- busy  out  1  high in any state other than IDLE
- done_pulse  out  1  one-cycle pulse when a frame completes normally
- timeout_err  out  1  one-cycle pulse when a frame is aborted
- done_id  out  $clog2(NUM_REQ)  requester index for done_pulse/timeout_err; holds last value

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE, frame_en=0, data_frame=0, done_pulse=0, timeout_err=0, done_id=0, busy=0.
  - last_gnt=NUM_REQ-1, so requester 0 has top priority first.
  - req_ready=0 while rst is high.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first asserted req_valid searching last_gnt+1, last_gnt+2, ... with modulo NUM_REQ wrap.
  - req_ready is all-zero if no req_valid is asserted, and always all-zero outside IDLE.
  - On grant: latch payload into data_frame, set cur_id=grant index, set last_gnt=grant index, go to LAUNCH.
- LAUNCH:
  - frame_en=1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT_DONE.
  - Latency: handshake at cycle t gives frame_en at t+1.
- WAIT_DONE:
  - frame_en=0; the timeout counter increments each cycle.
  - tx_done=1: next cycle done_pulse=1, done_id=cur_id; go to GAP.
  - Else, counter==TIMEOUT_CYC-1: next cycle timeout_err=1, done_id=cur_id; go to GAP.
  - tx_done and timeout in the same cycle: tx_done wins; no timeout_err.
- GAP:
  - Count GAP_CYC cycles, then return to IDLE.
  - GAP_CYC=0: one pass-through cycle in GAP, then IDLE.
  - Minimum spacing between successive frame_en pulses is GAP_CYC + 3 cycles plus the tx time.
- tx_done asserted in IDLE, LAUNCH or GAP is ignored.
- Requesters may drop req_valid before a grant; there is no stall or penalty. Payload is sampled only in the handshake cycle.
- Fairness: a requester that is continuously valid is granted within NUM_REQ frames.
- Reset mid-frame: all state returns to reset values in the next cycle. frame_en is not reissued. The tx instance is reset by the same system reset.
- Counter widths: $clog2(TIMEOUT_CYC) for the timeout counter, $clog2(GAP_CYC+1) for the gap counter. No overflow is possible since both compare before wrap.

Decomposition:
- Package uart_pkg:
  - sched_state_t enum (IDLE, LAUNCH, WAIT_DONE, GAP).
  - A function for round-robin one-hot next-grant given req vector and last index.
  - Shared FRAME_WD default constant.
- Sub-module rr_arbiter (parameter N): combinational grant vector and encoded index from req and last_gnt. Reusable by future rx/CSR arbiters.
- Top-level: FSM, counters and data register.

Test Plan:
- Single request: req_valid=4'b0001, req_data[7:0]=8'hA5 → req_ready=4'b0001 for 1 cycle; frame_en the next cycle with data_frame=8'hA5. Stub tx_done 20 cycles later → done_pulse=1, done_id=0; busy falls after 16 GAP cycles.
- Round-robin: all four valid continuously with data 8'h10/11/12/13 → grants in order 0,1,2,3,0. Frame_en spacing equals 3 + GAP_CYC cycles plus stub tx delay.
- Wrap priority: last_gnt=2, req_valid=4'b0101 → grant requester 0 (next after 2 with wrap is 3, then 0), not 2.
- Timeout: TIMEOUT_CYC=50, tx_done never asserted → timeout_err pulses exactly 51 cycles after frame_en, done_id=cur_id, no done_pulse; the next request is then served normally.
- Edge events: tx_done pulsed during GAP and IDLE → ignored, no done_pulse. tx_done on the same cycle as the terminal timeout count → done_pulse=1, timeout_err=0.
- Reset mid-frame: rst=1 in WAIT_DONE → next cycle busy=0, frame_en=0, data_frame=0. After release, requester 0 is granted first. Also run a loopback with real tx (50 MHz, 9600 baud) sending 8'h55 and check the serial waveform.
